main_memory_responder: RTL and testbench



---
 rtl/main_memory_responder_pkg.sv | 23 ++
 rtl/main_memory_responder_if.sv | 30 +++
 rtl/main_memory_responder_mem_block_array.sv | 28 ++
 rtl/main_memory_responder.sv | 142 ++++++++++++++
 tb/tb_main_memory_responder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/main_memory_responder_pkg.sv
// Shared types and width helpers for the L2 backing-store responder.
// The block typedef matches the L2 miss/allocate port at default sizing.
package mem_resp_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_BLOCK_SIZE = 16;
  localparam int DEF_MEM_BLOCKS = 256;

  localparam int OFF_W = $clog2(DEF_BLOCK_SIZE);
  localparam int IDX_W = $clog2(DEF_MEM_BLOCKS);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef logic [DEF_BLOCK_SIZE-1:0][DEF_DATA_WIDTH-1:0] block_t;

endpackage

// File: rtl/main_memory_responder_if.sv
// Request/response bundle between the L2 (master) and the memory responder (slave).
interface main_memory_responder_if
  import mem_resp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
);

  logic [ADDR_WIDTH-1:0]                 req_addr;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req_wdata;
  logic                                  req_read;
  logic                                  req_write;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] resp_rdata;
  logic                                  resp_ready;
  logic                                  resp_hit;
  logic                                  busy;
  logic                                  addr_err;

  modport master (
    output req_addr, req_wdata, req_read, req_write,
    input  resp_rdata, resp_ready, resp_hit, busy, addr_err
  );

  modport slave (
    input  req_addr, req_wdata, req_read, req_write,
    output resp_rdata, resp_ready, resp_hit, busy, addr_err
  );

endinterface

// File: rtl/main_memory_responder_mem_block_array.sv
// Block-wide storage: combinational read, synchronous write, contents never reset.
module mem_block_array
  import mem_resp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int MEM_BLOCKS = DEF_MEM_BLOCKS,
  localparam int IW        = $clog2(MEM_BLOCKS)
) (
  input  logic                                  clk,
  input  logic [IW-1:0]                         ridx,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rdata,
  input  logic                                  we,
  input  logic [IW-1:0]                         widx,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] wdata
);

  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem [MEM_BLOCKS];

  assign rdata = mem[ridx];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

endmodule

// File: rtl/main_memory_responder.sv
// L2 miss/allocate responder: accepts one block read/write, waits LATENCY cycles,
// pulses resp_ready, then waits for the initiator to drop its request.
module main_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int MEM_BLOCKS = DEF_MEM_BLOCKS,
  parameter int LATENCY    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  main_memory_responder_if.slave   bus
);

  localparam int OFF_BITS = $clog2(BLOCK_SIZE);
  localparam int IDX_BITS = $clog2(MEM_BLOCKS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  blk_t                  wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  blk_t                  rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  hit_q, hit_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic [IDX_BITS-1:0]   blk_idx;
  logic                  in_range;
  logic                  mem_we;
  blk_t                  mem_rdata;

  assign blk_idx  = addr_q[OFF_BITS+IDX_BITS-1:OFF_BITS];
  assign in_range = ((addr_q >> (OFF_BITS + IDX_BITS)) == '0);

  mem_block_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE),
    .MEM_BLOCKS (MEM_BLOCKS)
  ) u_mem (
    .clk   (clk),
    .ridx  (blk_idx),
    .rdata (mem_rdata),
    .we    (mem_we),
    .widx  (blk_idx),
    .wdata (wdata_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    hit_d   = 1'b0;
    err_d   = err_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_read || bus.req_write) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wr_d    = bus.req_write;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          ready_d = 1'b1;
          state_d = RESPOND;
          if (in_range) begin
            hit_d = 1'b1;
            if (wr_q) begin
              // Gate with rst_n so a reset on the commit edge aborts the write.
              mem_we  = rst_n;
              rdata_d = wdata_q;
            end else begin
              rdata_d = mem_rdata;
            end
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!bus.req_read && !bus.req_write) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
    // Capture registers carry request data only; no reset needed.
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wr_q    <= wr_d;
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_ready = ready_q;
  assign bus.resp_hit   = hit_q;
  assign bus.busy       = busy_q;
  assign bus.addr_err   = err_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Randomized bench for main_memory_responder against a block-level memory model.
module tb_main_memory_responder;
  import mem_resp_pkg::*;

  localparam int LAT = 4;

  logic clk;
  logic rst_n;

  main_memory_responder_if bus ();

  main_memory_responder #(
    .LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  block_t model [256];
  bit     valid [256];
  bit     err_m = 1'b0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic block_t rand_blk();
    block_t b;
    for (int i = 0; i < 16; i++) b[i] = $urandom;
    return b;
  endfunction

  // Starts just after the acceptance edge; checks latency, payload and release.
  task automatic wait_and_check(input bit rd, input bit wr, input logic [31:0] addr,
                                input block_t wd, input int hold);
    int     n;
    bit     seen;
    int     extra;
    bit     in_rng;
    int     idx;
    block_t exp_rd;
    bit     exp_hit;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_on_accept", bus.busy, 1'b1);
      if (n == 2) begin
        bus.req_addr  = $urandom;
        bus.req_wdata = rand_blk();
      end
      if (bus.resp_ready) seen = 1'b1;
    end
    chk("latency", n, LAT + 1);
    if (seen) begin
      in_rng = ((addr >> 12) == 0);
      idx    = int'(addr[11:4]);
      exp_rd = '0;
      exp_hit = in_rng;
      if (!in_rng) begin
        err_m = 1'b1;
        chk("rdata_oor", bus.resp_rdata, exp_rd);
      end else if (wr) begin
        model[idx] = wd;
        valid[idx] = 1'b1;
        chk("rdata_wr", bus.resp_rdata, wd);
      end else if (valid[idx]) begin
        chk("rdata_rd", bus.resp_rdata, model[idx]);
      end
      chk("hit", bus.resp_hit, exp_hit);
      chk("addr_err", bus.addr_err, err_m);
    end
    @(negedge clk);
    chk("pulse_len", bus.resp_ready, 1'b0);
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.resp_ready) extra++;
    end
    if (hold > 0) begin
      chk("extra_pulses", extra, 0);
      chk("busy_held", bus.busy, 1'b1);
    end
    @(posedge clk);
    #1;
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_released", bus.busy, 1'b0);
    if (rd && !wr && 0) chk("never", 0, 0);
  endtask

  task automatic xact(input bit rd, input bit wr, input logic [31:0] addr,
                      input block_t wd, input int hold);
    @(posedge clk);
    #1;
    bus.req_read  = rd;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    wait_and_check(rd, wr, addr, wd, hold);
  endtask

  block_t blk_a, blk_o, blk_b, blk_c;

  initial begin
    rst_n         = 1'b0;
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) valid[i] = 1'b0;
    for (int i = 0; i < 16; i++) blk_a[i] = 32'hA000_0000 + i;
    blk_o = rand_blk();
    blk_b = rand_blk();
    blk_c = rand_blk();

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.resp_ready, 1'b0);
    chk("rst_hit", bus.resp_hit, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", bus.addr_err, 1'b0);
    chk("rst_rdata", bus.resp_rdata, '0);

    xact(1'b0, 1'b1, 32'h0000_0040, blk_a, 0);
    xact(1'b1, 1'b0, 32'h0000_004C, '0, 0);
    chk("rd_word3", bus.resp_rdata[3], 32'hA000_0003);
    xact(1'b1, 1'b0, 32'h0000_0040, '0, 20);

    xact(1'b1, 1'b0, 32'h0001_0000, '0, 0);
    xact(1'b1, 1'b0, 32'h0000_004C, '0, 0);
    chk("err_sticky", bus.addr_err, 1'b1);

    // Reset during WAIT: the write of B must be lost, the held read re-accepted.
    xact(1'b0, 1'b1, 32'h0000_0080, blk_o, 0);
    @(posedge clk);
    #1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0000_0080;
    bus.req_wdata = blk_b;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.req_write = 1'b0;
    bus.req_read  = 1'b1;
    bus.req_addr  = 32'h0000_0080;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    err_m = 1'b0;
    @(negedge clk);
    chk("rstw_busy", bus.busy, 1'b0);
    chk("rstw_ready", bus.resp_ready, 1'b0);
    chk("rstw_err", bus.addr_err, 1'b0);
    @(posedge clk);
    wait_and_check(1'b1, 1'b0, 32'h0000_0080, '0, 0);
    chk("old_contents", bus.resp_rdata, blk_o);

    xact(1'b1, 1'b1, 32'h0000_00C0, blk_c, 0);
    chk("both_is_write", bus.resp_rdata, blk_c);
    xact(1'b1, 1'b0, 32'h0000_00C0, '0, 0);
    chk("readback_c", bus.resp_rdata, blk_c);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      bit          r, w;
      int          op;
      op = $urandom_range(0, 2);
      r  = (op != 1);
      w  = (op != 0);
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
      else a = {20'h0, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15))};
      if (t < 10) a = {20'h0, 4'h0, 4'(t), 4'($urandom_range(0, 15))};
      xact(r, w, a, rand_blk(), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
